program_loader: RTL and testbench

- Writer side of the instruction memory that the single-cycle CPU fetches from.
- Accepts a framed byte stream from a host link through a valid/ready byte interface.
- Assembles 10-bit instruction words from that stream and writes them sequentially into instruction RAM.
- Holds the CPU in reset (cpu_hold) until a complete image with a valid checksum has been written.

---
 rtl/loader_pkg.sv | 25 ++
 rtl/program_loader.sv | 140 ++++++++++++++
 tb/tb_program_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the instruction-image loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

    typedef enum logic [2:0] {
        WAIT_SYNC = 3'd0,
        GET_COUNT = 3'd1,
        GET_HI    = 3'd2,
        GET_LO    = 3'd3,
        GET_SUM   = 3'd4,
        DONE      = 3'd5,
        ERROR     = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] RSVD_MASK     = 8'hFC;

endpackage

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Receives a framed byte image, writes 10-bit words to imem and
//               releases the CPU once the checksum has been verified.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         INSTR_W   = 10,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    words_loaded
);

    localparam int CNT_W = ADDR_W + 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_word_count;
    logic [1:0]       r_hi_bits;
    logic [7:0]       r_checksum;
    logic             w_accept;

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= WAIT_SYNC;
            r_word_count <= '0;
            r_hi_bits    <= '0;
            r_checksum   <= '0;
            in_ready     <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            // Write strobe and the ready bubble each last a single cycle.
            imem_we  <= 1'b0;
            in_ready <= 1'b1;

            if (w_accept) begin
                case (r_state)
                    WAIT_SYNC: begin
                        if (in_data == SYNC_BYTE)
                            r_state <= GET_COUNT;
                    end

                    GET_COUNT: begin
                        // A count byte of zero stands for a full 2**ADDR_W image.
                        if (in_data == 8'h00)
                            r_word_count <= CNT_W'(1) << ADDR_W;
                        else
                            r_word_count <= CNT_W'(in_data);
                        imem_addr    <= '0;
                        words_loaded <= '0;
                        r_checksum   <= in_data;
                        r_state      <= GET_HI;
                    end

                    GET_HI: begin
                        if ((in_data & RSVD_MASK) != 8'h00) begin
                            error    <= 1'b1;
                            cpu_hold <= 1'b1;
                            r_state  <= ERROR;
                        end else begin
                            r_hi_bits  <= in_data[1:0];
                            r_checksum <= r_checksum ^ in_data;
                            r_state    <= GET_LO;
                        end
                    end

                    GET_LO: begin
                        r_checksum   <= r_checksum ^ in_data;
                        imem_we      <= 1'b1;
                        imem_addr    <= words_loaded[ADDR_W-1:0];
                        imem_wdata   <= INSTR_W'({r_hi_bits, in_data});
                        words_loaded <= words_loaded + CNT_W'(1);
                        in_ready     <= 1'b0;
                        if ((words_loaded + CNT_W'(1)) == r_word_count)
                            r_state <= GET_SUM;
                        else
                            r_state <= GET_HI;
                    end

                    GET_SUM: begin
                        if (in_data == r_checksum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            r_state  <= DONE;
                        end else begin
                            error    <= 1'b1;
                            cpu_hold <= 1'b1;
                            r_state  <= ERROR;
                        end
                    end

                    DONE: begin
                        if (in_data == SYNC_BYTE) begin
                            done     <= 1'b0;
                            cpu_hold <= 1'b1;
                            r_state  <= GET_COUNT;
                        end
                    end

                    ERROR: begin
                        if (in_data == SYNC_BYTE) begin
                            error   <= 1'b0;
                            r_state <= GET_COUNT;
                        end
                    end

                    default: begin
                        r_state <= WAIT_SYNC;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [9:0] imem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [8:0] words_loaded;

    int n_cmp = 0;
    int n_mis = 0;
    int nw    = 0;

    logic [9:0] tw [0:255];

    program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we)
            nw = nw + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents a byte from a negedge and returns on the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit use_bad, input logic [7:0] bad_sum);
        logic [7:0] cnt;
        logic [7:0] cs;
        logic [7:0] hi;
        logic [7:0] lo;
        int w0;
        cnt = n[7:0];
        cs  = cnt;
        w0  = nw;
        send_byte(8'hA5);
        check("hold_on_sync", {31'd0, cpu_hold}, 32'd1);
        check("done_clr_on_sync", {31'd0, done}, 32'd0);
        send_byte(cnt);
        for (int i = 0; i < n; i++) begin
            hi = {6'd0, tw[i][9:8]};
            lo = tw[i][7:0];
            cs = cs ^ hi ^ lo;
            send_byte(hi);
            send_byte(lo);
            check("we_after_lo", {31'd0, imem_we}, 32'd1);
            check("wr_addr", {24'd0, imem_addr}, i);
            check("wr_data", {22'd0, imem_wdata}, {22'd0, tw[i]});
            check("words_loaded_step", {23'd0, words_loaded}, i + 1);
        end
        send_byte(use_bad ? bad_sum : cs);
        check("write_count", nw - w0, n);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_error"},    {31'd0, error},    32'd0);
        check({tag, "_we"},       {31'd0, imem_we},  32'd0);
        check({tag, "_addr"},     {24'd0, imem_addr}, 32'd0);
        check({tag, "_wdata"},    {22'd0, imem_wdata}, 32'd0);
        check({tag, "_wl"},       {23'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        int w0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;
        @(negedge clk);

        // Two-word image; checksum 02^01^23^00^FF = DF.
        tw[0] = 10'h123;
        tw[1] = 10'h0FF;
        send_frame(2, 1'b0, 8'h00);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_hold", {31'd0, cpu_hold}, 32'd0);
        check("t1_error", {31'd0, error}, 32'd0);
        check("t1_wl", {23'd0, words_loaded}, 32'd2);

        // Same image with a bad checksum, starting from DONE.
        send_frame(2, 1'b1, 8'h00);
        check("t2_error", {31'd0, error}, 32'd1);
        check("t2_hold", {31'd0, cpu_hold}, 32'd1);
        check("t2_done", {31'd0, done}, 32'd0);

        send_frame(2, 1'b0, 8'h00);
        check("t3_error", {31'd0, error}, 32'd0);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_hold", {31'd0, cpu_hold}, 32'd0);

        // Reserved HI bit set: rejected without any write.
        w0 = nw;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h04);
        check("t4_error", {31'd0, error}, 32'd1);
        check("t4_hold", {31'd0, cpu_hold}, 32'd1);
        check("t4_done", {31'd0, done}, 32'd0);
        send_byte(8'h55);
        check("t4_no_write", nw - w0, 0);
        check("t4_error_sticky", {31'd0, error}, 32'd1);

        // Leading garbage is discarded; checksum 01^03^FF = FD.
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'hA4);
        tw[0] = 10'h3FF;
        send_frame(1, 1'b0, 8'h00);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_error", {31'd0, error}, 32'd0);

        // COUNT=00 encodes a full 256-word image.
        for (int i = 0; i < 256; i++)
            tw[i] = 10'((i * 7 + 5) ^ (i << 2));
        send_frame(256, 1'b0, 8'h00);
        check("t6_wl", {23'd0, words_loaded}, 32'd256);
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_hold", {31'd0, cpu_hold}, 32'd0);

        // Reset after one of three words aborts the frame.
        w0 = nw;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h23);
        send_byte(8'h02);
        check("t7_one_write", nw - w0, 1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("t7");
        reset = 1'b1;
        @(negedge clk);
        send_byte(8'h45);
        send_byte(8'h67);
        check("t7_no_more_writes", nw - w0, 1);
        check("t7_done", {31'd0, done}, 32'd0);
        check("t7_hold", {31'd0, cpu_hold}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
